// File: rtl/apb_master.sv
// Single-outstanding APB master: takes one command, runs one SETUP/ACCESS transfer
// (or rejects a misaligned address locally), and holds the response until it is consumed.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16  // legal range 1..255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // The APB bus registers double as the latched command for the whole transfer.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // NOTE: non-blocking assignments; a later assignment to the same register
          // in this block overrides the default given first.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_addr[1:0] != 2'b00) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state    <= SETUP;
              psel     <= 1'b1;
              paddr    <= cmd_addr;
              pwrite   <= cmd_write;
              pwdata   <= cmd_write ? cmd_wdata : 32'h0;
              wait_cnt <= '0;
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          if (!pready) wait_cnt <= wait_cnt + 8'd1;
          // A ready slave wins over a timeout falling on the same cycle.
          if (pready || wait_cnt == LAST_WAIT) begin
            state     <= RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b1;
            if (pready) begin
              rsp_err     <= pslverr;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= (!pwrite && !pslverr) ? prdata : 32'h0;
            end else begin
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
